// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolver: in-order FIFO of predicted branches, compared against
// resolved outcomes to drive predictor updates, flushes and redirect PCs.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic                     pred_not_taken,
    input  logic [AW-1:0]            pred_target,
    input  logic [AW-1:0]            pred_fallthru,
    output logic                     fifo_full,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     BR,
    output logic                     Taken,
    output logic                     flush,
    output logic [AW-1:0]            redirect_pc,
    output logic [CNT_W-1:0]         mispredict_cnt,
    output logic                     resolve_err,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic          taken;
        logic [AW-1:0] target;
        logic [AW-1:0] fallthru;
    } entry_t;

    typedef enum logic {RUN, RECOVER} state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    state_t        state, state_nxt;
    logic          pop, push, mis;

    assign head = mem[rd_ptr];
    assign pop  = resolve_valid && (occupancy != '0);
    assign mis  = pop && (head.taken != resolve_taken);
    // A pop frees a slot in the same edge, so a full FIFO may still accept;
    // the younger push is squashed whenever the pop mispredicts.
    assign push = pred_valid && (state == RUN) && ((occupancy != FULL_CNT) || pop) && !mis;

    always_comb begin
        state_nxt = state;
        fifo_full = (occupancy == FULL_CNT);
        case (state)
            RUN:     if (mis) state_nxt = RECOVER;
            RECOVER: begin
                state_nxt = RUN;
                fifo_full = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (mis) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occupancy <= occupancy + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{taken: ~pred_not_taken, target: pred_target, fallthru: pred_fallthru};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BR             <= 1'b0;
            Taken          <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            resolve_err    <= 1'b0;
        end else begin
            BR          <= pop;
            Taken       <= pop && resolve_taken;
            flush       <= mis;
            redirect_pc <= mis ? (resolve_taken ? head.target : head.fallthru) : '0;
            if (mis && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
            if (resolve_valid && (occupancy == '0)) resolve_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: vector table through a scoreboard queue, plus
// directed sequences for saturation, sticky error and mid-operation reset.
module tb_branch_resolve_unit;
    localparam int AW = 16;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic pv, pnt, rv, rt;
    logic [AW-1:0] tgt, ft;
    logic full, br, tk, fl, err;
    logic [AW-1:0] rpc;
    logic [15:0] cnt;
    logic [2:0] occ;

    branch_resolve_unit #(.DEPTH(4), .AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pred_valid(pv), .pred_not_taken(pnt),
        .pred_target(tgt), .pred_fallthru(ft), .fifo_full(full),
        .resolve_valid(rv), .resolve_taken(rt), .BR(br), .Taken(tk), .flush(fl),
        .redirect_pc(rpc), .mispredict_cnt(cnt), .resolve_err(err), .occupancy(occ));

    // Small build for counter saturation
    logic s_pv, s_pnt, s_rv, s_rt, s_full, s_br, s_tk, s_fl, s_err;
    logic [AW-1:0] s_rpc;
    logic [1:0] s_cnt, s_occ;

    branch_resolve_unit #(.DEPTH(2), .AW(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .pred_valid(s_pv), .pred_not_taken(s_pnt),
        .pred_target(16'h0aa0), .pred_fallthru(16'h0aa1), .fifo_full(s_full),
        .resolve_valid(s_rv), .resolve_taken(s_rt), .BR(s_br), .Taken(s_tk), .flush(s_fl),
        .redirect_pc(s_rpc), .mispredict_cnt(s_cnt), .resolve_err(s_err), .occupancy(s_occ));

    typedef struct {
        logic pv, pnt; logic [AW-1:0] tgt, ft; logic rv, rt;
        logic br, tk, fl; logic [AW-1:0] rpc; logic [2:0] occ; logic full, err; logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic p, input logic n, input logic [AW-1:0] t, input logic [AW-1:0] f,
                       input logic r, input logic rtk, input logic b, input logic k, input logic fl_e,
                       input logic [AW-1:0] pc, input logic [2:0] o, input logic fu, input logic e,
                       input logic [15:0] c);
        vec_t v;
        v = '{pv:p, pnt:n, tgt:t, ft:f, rv:r, rt:rtk, br:b, tk:k, fl:fl_e, rpc:pc, occ:o, full:fu, err:e, cnt:c};
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        pv = 0; pnt = 0; tgt = 0; ft = 0; rv = 0; rt = 0;
    endtask

    initial begin
        vec_t e;
        idle_inputs();
        s_pv = 0; s_pnt = 0; s_rv = 0; s_rt = 0;

        //   pv pnt tgt      ft       rv rt  br tk fl rpc      occ full err cnt
        add(1, 0, 16'h0040, 16'h0041, 0, 0,  0, 0, 0, 16'h0000, 1, 0, 0, 0);  // test 1
        add(0, 0, 16'h0000, 16'h0000, 1, 1,  1, 1, 0, 16'h0000, 0, 0, 0, 0);
        add(1, 0, 16'h0100, 16'h0011, 0, 0,  0, 0, 0, 16'h0000, 1, 0, 0, 0);  // test 2
        add(0, 0, 16'h0000, 16'h0000, 1, 0,  1, 0, 1, 16'h0011, 0, 1, 0, 1);
        add(1, 1, 16'h0900, 16'h0901, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 0, 1);  // push in RECOVER dropped
        add(1, 0, 16'h0200, 16'h0201, 0, 0,  0, 0, 0, 16'h0000, 1, 0, 0, 1);  // test 3
        add(1, 1, 16'h0210, 16'h0211, 0, 0,  0, 0, 0, 16'h0000, 2, 0, 0, 1);
        add(1, 0, 16'h0220, 16'h0221, 0, 0,  0, 0, 0, 16'h0000, 3, 0, 0, 1);
        add(1, 1, 16'h0230, 16'h0231, 0, 0,  0, 0, 0, 16'h0000, 4, 1, 0, 1);
        add(1, 0, 16'h0240, 16'h0241, 0, 0,  0, 0, 0, 16'h0000, 4, 1, 0, 1);  // 5th push dropped
        add(0, 0, 16'h0000, 16'h0000, 1, 1,  1, 1, 0, 16'h0000, 3, 0, 0, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 0,  1, 0, 0, 16'h0000, 2, 0, 0, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 1,  1, 1, 0, 16'h0000, 1, 0, 0, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 1);
        add(1, 0, 16'h0250, 16'h0251, 0, 0,  0, 0, 0, 16'h0000, 1, 0, 0, 1);  // refill, push+pop at full
        add(1, 0, 16'h0260, 16'h0261, 0, 0,  0, 0, 0, 16'h0000, 2, 0, 0, 1);
        add(1, 0, 16'h0270, 16'h0271, 0, 0,  0, 0, 0, 16'h0000, 3, 0, 0, 1);
        add(1, 0, 16'h0280, 16'h0281, 0, 0,  0, 0, 0, 16'h0000, 4, 1, 0, 1);
        add(1, 1, 16'h0300, 16'h0301, 1, 1,  1, 1, 0, 16'h0000, 4, 1, 0, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 1,  1, 1, 0, 16'h0000, 3, 0, 0, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 1,  1, 1, 0, 16'h0000, 2, 0, 0, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 1,  1, 1, 0, 16'h0000, 1, 0, 0, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 1);  // entry pushed at full
        add(1, 1, 16'h0400, 16'h0401, 0, 0,  0, 0, 0, 16'h0000, 1, 0, 0, 1);  // test 4
        add(1, 0, 16'h0410, 16'h0411, 0, 0,  0, 0, 0, 16'h0000, 2, 0, 0, 1);
        add(1, 0, 16'h0500, 16'h0501, 1, 1,  1, 1, 1, 16'h0400, 0, 1, 0, 2);
        add(0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 0, 2);
        add(0, 0, 16'h0000, 16'h0000, 1, 1,  0, 0, 0, 16'h0000, 0, 0, 1, 2);  // test 5
        add(0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 1, 2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_br", br, 0);  chk("rst_taken", tk, 0); chk("rst_flush", fl, 0);
        chk("rst_rpc", rpc, 0); chk("rst_cnt", cnt, 0); chk("rst_err", err, 0);
        chk("rst_occ", occ, 0); chk("rst_full", full, 0);
        @(negedge clk); rst = 0;

        foreach (tbl[i]) begin
            @(negedge clk);
            pv = tbl[i].pv; pnt = tbl[i].pnt; tgt = tbl[i].tgt; ft = tbl[i].ft;
            rv = tbl[i].rv; rt = tbl[i].rt;
            sb.push_back(tbl[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_br", i), br, e.br);
            chk($sformatf("v%0d_taken", i), tk, e.tk);
            chk($sformatf("v%0d_flush", i), fl, e.fl);
            if (e.fl) chk($sformatf("v%0d_rpc", i), rpc, e.rpc);
            chk($sformatf("v%0d_occ", i), occ, e.occ);
            chk($sformatf("v%0d_full", i), full, e.full);
            chk($sformatf("v%0d_err", i), err, e.err);
            chk($sformatf("v%0d_cnt", i), cnt, e.cnt);
        end
        @(negedge clk); idle_inputs();

        // Saturation: predicted taken, resolved not-taken, four times
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); s_pv = 1; s_pnt = 0;
            @(negedge clk); s_pv = 0; s_rv = 1; s_rt = 0;
            @(posedge clk); #1;
            chk($sformatf("sat%0d_flush", k), s_fl, 1);
            chk($sformatf("sat%0d_rpc", k), s_rpc, 16'h0aa1);
            chk($sformatf("sat%0d_cnt", k), s_cnt, (k < 3) ? k + 1 : 3);
            @(negedge clk); s_rv = 0;
        end

        // Sticky error cleared only by reset
        chk("err_sticky", err, 1);
        @(negedge clk); rst = 1;
        #1;
        chk("err_cleared", err, 0); chk("cnt_cleared", cnt, 0);
        @(negedge clk); rst = 0;

        // Reset right after a resolve edge drops the pending BR pulse
        @(negedge clk); pv = 1; pnt = 1; tgt = 16'h0600; ft = 16'h0601;
        @(negedge clk); pv = 0; rv = 1; rt = 0;
        @(posedge clk); #1;
        chk("midrst_br_before", br, 1);
        rst = 1; #1;
        chk("midrst_br_after", br, 0);
        chk("midrst_occ", occ, 0);
        chk("midrst_full", full, 0);
        @(negedge clk); rst = 0; idle_inputs();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
